// File: rtl/ram64_arb_pkg.sv
// ram64_arb_pkg: shared types and default widths for the ram64 arbiter
package ram64_arb_pkg;
    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 6;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
    typedef logic port_id_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way one-hot grant, prio names the winner when both request
import ram64_arb_pkg::*;
module rr_pick2 (
    input  logic [1:0] req,
    input  port_id_t   prio,
    output logic [1:0] gnt
);
    always_comb begin
        gnt[0] = req[0] & (~req[1] | ~prio);
        gnt[1] = req[1] & (~req[0] | prio);
    end
endmodule

// File: rtl/ram64_arbiter.sv
// ram64_arbiter: round-robin two-port sequencer driving a single ram64,
// one access per IDLE->ACCESS->RESP pass
import ram64_arb_pkg::*;
module ram64_arbiter #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_rsp_valid,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);
    arb_state_t        state_q;
    port_id_t          rr_q;
    port_id_t          id_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        gnt;
    logic              idle;

    rr_pick2 u_pick (
        .req  ({p1_valid, p0_valid}),
        .prio (rr_q),
        .gnt  (gnt)
    );

    always_comb begin
        idle         = (state_q == IDLE) & ~rst;
        p0_ready     = idle & gnt[0];
        p1_ready     = idle & gnt[1];
        busy         = state_q != IDLE;
        ram_addr     = addr_q;
        ram_in       = wdata_q;
        ram_load     = (state_q == ACCESS) & we_q & ~rst;
        p0_rsp_valid = (state_q == RESP) & ~id_q;
        p1_rsp_valid = (state_q == RESP) & id_q;
        rsp_rdata    = rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (|gnt) begin
                    id_q    <= gnt[1];
                    we_q    <= gnt[1] ? p1_we : p0_we;
                    addr_q  <= gnt[1] ? p1_addr : p0_addr;
                    wdata_q <= gnt[1] ? p1_wdata : p0_wdata;
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    rdata_q <= we_q ? '0 : ram_out;
                    state_q <= RESP;
                end
                RESP: begin
                    rr_q    <= ~id_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram64_arbiter.sv
// tb_ram64_arbiter: random and directed traffic against a transaction-level
// model of grant timing, round-robin order and memory contents
module tb_ram64_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        p0_valid, p0_ready, p0_we, p1_valid, p1_ready, p1_we;
    logic [5:0]  p0_addr, p1_addr, ram_addr;
    logic [63:0] p0_wdata, p1_wdata, rsp_rdata, ram_in, ram_out;
    logic        p0_rsp_valid, p1_rsp_valid, busy, ram_load;
    logic [63:0] mem [64];
    logic        pl_en;
    logic [5:0]  pl_addr;
    logic [63:0] pl_data;

    logic [63:0] ref_mem [64];
    int          cyc, g_cyc, g_port, last_win;
    logic        g_we;
    logic [5:0]  g_addr;
    logic [63:0] g_wdata, g_rdata;
    logic        hs0, hs1;
    int          checks = 0, errors = 0;
    int          mode, prev, sat_grants;

    always #5 clk = ~clk;

    ram64_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_rsp_valid(p0_rsp_valid), .p1_rsp_valid(p1_rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .ram_in(ram_in), .ram_addr(ram_addr), .ram_load(ram_load), .ram_out(ram_out)
    );

    // the ram64 instance: combinational read, synchronous write, plus a preload port
    assign ram_out = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_load) mem[ram_addr] <= ram_in;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: check outputs against the schedule, then advance the model.
    // A grant at cycle g means access at g+1, response at g+2, next grant from g+3.
    task automatic step();
        logic idle, acc, rsp;
        int   win;
        @(negedge clk);
        idle = cyc >= g_cyc + 3;
        acc  = cyc == g_cyc + 1;
        rsp  = cyc == g_cyc + 2;
        win  = -1;
        if (idle && !rst)
            win = (p0_valid && p1_valid) ? (last_win == 0 ? 1 : 0) : p0_valid ? 0 : p1_valid ? 1 : -1;
        check("p0_ready", p0_ready, win == 0);
        check("p1_ready", p1_ready, win == 1);
        check("busy", busy, !idle);
        check("ram_load", ram_load, acc && g_we && !rst);
        if (acc) begin
            check("ram_addr", ram_addr, g_addr);
            check("ram_in", ram_in, g_wdata);
        end
        check("p0_rsp_valid", p0_rsp_valid, rsp && g_port == 0);
        check("p1_rsp_valid", p1_rsp_valid, rsp && g_port == 1);
        if (rsp) check("rsp_rdata", rsp_rdata, g_rdata);
        hs0 = p0_valid && p0_ready;
        hs1 = p1_valid && p1_ready;
        @(posedge clk);
        if (rst) begin
            g_cyc    = cyc - 2;
            last_win = 1;
        end else begin
            if (acc) begin
                g_rdata = g_we ? 64'd0 : ref_mem[g_addr];
                if (g_we) ref_mem[g_addr] = g_wdata;
            end
            if (win >= 0) begin
                g_cyc    = cyc;
                g_port   = win;
                last_win = win;
                g_we     = win == 1 ? p1_we : p0_we;
                g_addr   = win == 1 ? p1_addr : p0_addr;
                g_wdata  = win == 1 ? p1_wdata : p0_wdata;
            end
        end
        cyc++;
    endtask

    task automatic preload(input logic [5:0] a, input logic [63:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        step();
        #1 pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic new_req(input int p);
        logic        we;
        logic [5:0]  a;
        logic [63:0] d;
        we = 1'($urandom_range(0, 1));
        a  = $urandom_range(0, 1) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
        d  = {$urandom, $urandom};
        if (p == 0) begin
            p0_we = we; p0_addr = a; p0_wdata = d; p0_valid = 1'b1;
        end else begin
            p1_we = we; p1_addr = a; p1_wdata = d; p1_valid = 1'b1;
        end
    endtask

    task automatic run(input int n);
        int cur;
        for (int i = 0; i < n; i++) begin
            step();
            if (mode == 1 && (hs0 || hs1)) begin
                cur = hs1 ? 1 : 0;
                sat_grants++;
                if (prev >= 0) check("alternate", 64'(cur), 64'(prev == 0 ? 1 : 0));
                prev = cur;
            end
            #1;
            if (hs0) p0_valid = 1'b0;
            if (hs1) p1_valid = 1'b0;
            if (mode != 0) begin
                if (!p0_valid && (mode == 1 || $urandom_range(0, 2) == 0)) new_req(0);
                if (!p1_valid && (mode == 1 || $urandom_range(0, 2) == 0)) new_req(1);
            end
        end
    endtask

    initial begin
        rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        p0_valid = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_valid = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        cyc = 0; g_cyc = -10; g_port = 0; last_win = 1; mode = 0; prev = -1; sat_grants = 0;
        g_we = 0; g_addr = '0; g_wdata = '0; g_rdata = '0;
        @(posedge clk);
        #1;
        p0_valid = 1'b1; p1_valid = 1'b1;
        for (int a = 0; a < 64; a++) preload(6'(a), {$urandom, $urandom});
        p0_valid = 1'b0; p1_valid = 1'b0;
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_in", ram_in, 0);
        rst = 1'b0;
        preload(6'd5, 64'hDEAD_BEEF);
        p0_we = 0; p0_addr = 6'd5; p0_valid = 1'b1;
        run(4);
        p1_we = 1; p1_addr = 6'd63; p1_wdata = 64'h0123_4567_89AB_CDEF; p1_valid = 1'b1;
        run(4);
        p1_we = 0; p1_addr = 6'd63; p1_wdata = '0; p1_valid = 1'b1;
        run(4);
        p0_we = 0; p0_addr = 6'd1; p0_valid = 1'b1;
        p1_we = 0; p1_addr = 6'd2; p1_valid = 1'b1;
        run(7);
        mode = 1; prev = -1; sat_grants = 0;
        new_req(0); new_req(1);
        run(12);
        check("sat_grants", 64'(sat_grants), 4);
        mode = 2;
        run(400);
        mode = 0;
        run(10);
        preload(6'd7, 64'd0);
        p0_we = 1; p0_addr = 6'd7; p0_wdata = 64'hFFFF; p0_valid = 1'b1;
        run(1);
        rst = 1'b1;
        step();
        #1 rst = 1'b0;
        step();
        check("rst_mid_write_mem7", mem[7], 0);
        run(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
